// File: rtl/pipeline_rr_arbiter_if.sv
// Handshake bundle between N upstream requesters, the arbiter and the downstream stage.
interface pipeline_rr_arbiter_if #(
    parameter int unsigned N      = 4,
    parameter int unsigned DATA_N = 32,
    parameter int unsigned ID_N   = 2
);

    // Upstream side
    logic [N-1:0]        iREQ_VALID;
    logic [N-1:0]        iREQ_LAST;
    logic [N*DATA_N-1:0] iREQ_DATA;
    logic [N-1:0]        oREQ_BUSY;

    // Downstream side (connects to a pipeline stage's iPREV_* ports)
    logic                oNEXT_VALID;
    logic                iNEXT_BUSY;
    logic [DATA_N-1:0]   oNEXT_DATA;
    logic [ID_N-1:0]     oNEXT_ID;
    logic                oNEXT_LAST;

    // Status
    logic                oLOCKED;

    // Arbiter view
    modport slave (
        input  iREQ_VALID,
        input  iREQ_LAST,
        input  iREQ_DATA,
        input  iNEXT_BUSY,
        output oREQ_BUSY,
        output oNEXT_VALID,
        output oNEXT_DATA,
        output oNEXT_ID,
        output oNEXT_LAST,
        output oLOCKED
    );

    // Environment view: drives requests and downstream busy
    modport master (
        output iREQ_VALID,
        output iREQ_LAST,
        output iREQ_DATA,
        output iNEXT_BUSY,
        input  oREQ_BUSY,
        input  oNEXT_VALID,
        input  oNEXT_DATA,
        input  oNEXT_ID,
        input  oNEXT_LAST,
        input  oLOCKED
    );

endinterface

// File: rtl/pipeline_rr_arbiter.sv
// Round-robin arbiter with packet locking feeding a single registered pipeline slot.
// A multi-beat packet keeps the grant until its last beat; the round-robin pointer
// only moves when a packet completes, so fairness is per packet.
module pipeline_rr_arbiter #(
    parameter int unsigned N      = 4,
    parameter int unsigned DATA_N = 32,
    parameter int unsigned ID_N   = 2
) (
    input  logic                   iCLOCK,
    input  logic                   iRESET,
    input  logic                   iRESET_SYNC,
    pipeline_rr_arbiter_if.slave   bus
);

    localparam int unsigned PTR_INIT = N - 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    // Registered state
    state_t              b_state;
    logic                b_valid;
    logic [DATA_N-1:0]   b_data;
    logic [ID_N-1:0]     b_id;
    logic                b_last;
    logic [ID_N-1:0]     b_owner;
    logic [ID_N-1:0]     b_ptr;

    // Combinational decode
    logic                load_c;
    logic                grant_valid_c;
    logic [ID_N-1:0]     grant_c;
    logic [DATA_N-1:0]   sel_data_c;
    logic                sel_last_c;
    logic [N-1:0]        req_busy_c;
    logic                reset_any_c;

    // Per-requester data slices
    logic [DATA_N-1:0]   req_data [N];

    for (genvar g = 0; g < int'(N); g++) begin : g_slice
        assign req_data[g] = bus.iREQ_DATA[g*DATA_N +: DATA_N];
    end

    assign reset_any_c = iRESET | iRESET_SYNC;

    // Slot can take a new beat when empty or when downstream drains it this cycle
    assign load_c = !b_valid || !bus.iNEXT_BUSY;

    // Grant selection: locked owner only, otherwise round-robin search after b_ptr
    always_comb begin
        grant_valid_c = 1'b0;
        grant_c       = '0;
        if (b_state == ST_LOCK) begin
            grant_c = b_owner;
            for (int i = 0; i < int'(N); i++) begin
                if (ID_N'(i) == b_owner) begin
                    grant_valid_c = bus.iREQ_VALID[i];
                end
            end
        end else begin
            // Indices above the pointer have priority, then wrap to 0..b_ptr
            for (int i = 0; i < int'(N); i++) begin
                if (!grant_valid_c && bus.iREQ_VALID[i] && (ID_N'(i) > b_ptr)) begin
                    grant_valid_c = 1'b1;
                    grant_c       = ID_N'(i);
                end
            end
            for (int i = 0; i < int'(N); i++) begin
                if (!grant_valid_c && bus.iREQ_VALID[i] && (ID_N'(i) <= b_ptr)) begin
                    grant_valid_c = 1'b1;
                    grant_c       = ID_N'(i);
                end
            end
        end
    end

    // Mux the granted requester's payload
    always_comb begin
        sel_data_c = '0;
        sel_last_c = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            if (ID_N'(i) == grant_c) begin
                sel_data_c = req_data[i];
                sel_last_c = bus.iREQ_LAST[i];
            end
        end
    end

    // Per-requester busy: only the granted requester is released, and only on a load
    always_comb begin
        req_busy_c = '1;
        if (!reset_any_c) begin
            for (int i = 0; i < int'(N); i++) begin
                req_busy_c[i] = !(load_c && grant_valid_c && (grant_c == ID_N'(i)));
            end
        end
    end

    assign bus.oREQ_BUSY = req_busy_c;

    // Output slot, lock FSM and round-robin pointer
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            b_state <= ST_IDLE;
            b_valid <= 1'b0;
            b_data  <= '0;
            b_id    <= '0;
            b_last  <= 1'b0;
            b_owner <= '0;
            b_ptr   <= ID_N'(PTR_INIT);
        end else if (iRESET_SYNC) begin
            b_state <= ST_IDLE;
            b_valid <= 1'b0;
            b_data  <= '0;
            b_id    <= '0;
            b_last  <= 1'b0;
            b_owner <= '0;
            b_ptr   <= ID_N'(PTR_INIT);
        end else if (load_c) begin
            b_valid <= grant_valid_c;
            if (grant_valid_c) begin
                b_data <= sel_data_c;
                b_id   <= grant_c;
                b_last <= sel_last_c;
                case (b_state)
                    ST_IDLE: begin
                        if (!sel_last_c) begin
                            b_state <= ST_LOCK;
                            b_owner <= grant_c;
                        end else begin
                            b_ptr <= grant_c;
                        end
                    end
                    ST_LOCK: begin
                        if (sel_last_c) begin
                            b_state <= ST_IDLE;
                            b_ptr   <= b_owner;
                        end
                    end
                    default: b_state <= ST_IDLE;
                endcase
            end
        end
    end

    // Downstream outputs straight from the registers
    assign bus.oNEXT_VALID = b_valid;
    assign bus.oNEXT_DATA  = b_data;
    assign bus.oNEXT_ID    = b_id;
    assign bus.oNEXT_LAST  = b_last;
    assign bus.oLOCKED     = (b_state == ST_LOCK);

endmodule

// File: tb/tb_pipeline_rr_arbiter.sv
// Directed, table-driven bench for pipeline_rr_arbiter (N=4, DATA_N=32, ID_N=2).
module tb_pipeline_rr_arbiter;

    localparam int unsigned N      = 4;
    localparam int unsigned DATA_N = 32;
    localparam int unsigned ID_N   = 2;

    logic clk;
    logic rst;
    logic rst_sync;

    int errors = 0;
    int checks = 0;

    pipeline_rr_arbiter_if #(.N(N), .DATA_N(DATA_N), .ID_N(ID_N)) bus ();

    pipeline_rr_arbiter #(.N(N), .DATA_N(DATA_N), .ID_N(ID_N)) dut (
        .iCLOCK      (clk),
        .iRESET      (rst),
        .iRESET_SYNC (rst_sync),
        .bus         (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  v;
        logic [3:0]  l;
        logic [7:0]  tag;
        logic        nb;
        logic        rs;
        logic [3:0]  e_busy;
        logic        e_valid;
        logic [31:0] e_data;
        logic [1:0]  e_id;
        logic        e_last;
        logic        e_lock;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [3:0] v, logic [3:0] l, logic [7:0] tag, logic nb, logic rs,
                                logic [3:0] e_busy, logic e_valid, logic [31:0] e_data,
                                logic [1:0] e_id, logic e_last, logic e_lock);
        vec_t r;
        r.v = v; r.l = l; r.tag = tag; r.nb = nb; r.rs = rs;
        r.e_busy = e_busy; r.e_valid = e_valid; r.e_data = e_data;
        r.e_id = e_id; r.e_last = e_last; r.e_lock = e_lock;
        return r;
    endfunction

    // Requester i presents tag + i
    function automatic logic [N*DATA_N-1:0] pack_data(logic [7:0] tag);
        logic [N*DATA_N-1:0] d;
        d = '0;
        for (int i = 0; i < int'(N); i++) begin
            d[i*DATA_N +: DATA_N] = 32'(tag) + 32'(i);
        end
        return d;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(logic [3:0] v, logic [3:0] l, logic [7:0] tag, logic nb);
        bus.iREQ_VALID = v;
        bus.iREQ_LAST  = l;
        bus.iREQ_DATA  = pack_data(tag);
        bus.iNEXT_BUSY = nb;
    endtask

    task automatic chk_out(string name, logic e_valid, logic [31:0] e_data, logic [1:0] e_id,
                           logic e_last, logic e_lock);
        chk({name, " valid"}, 32'(bus.oNEXT_VALID), 32'(e_valid));
        chk({name, " locked"}, 32'(bus.oLOCKED), 32'(e_lock));
        if (e_valid) begin
            chk({name, " data"}, bus.oNEXT_DATA, e_data);
            chk({name, " id"}, 32'(bus.oNEXT_ID), 32'(e_id));
            chk({name, " last"}, 32'(bus.oNEXT_LAST), 32'(e_last));
        end
    endtask

    initial begin
        rst      = 1'b1;
        rst_sync = 1'b0;
        drive(4'b0000, 4'b0000, 8'h00, 1'b0);

        // Vectors: v, l, tag, nb, rs | busy, valid, data, id, last, locked (state after the edge)
        // Single requester
        vecs.push_back(mk(4'b0100, 4'b1111, 8'hA3, 0, 0, 4'b1011, 1, 32'hA5, 2, 1, 0));
        vecs.push_back(mk(4'b0000, 4'b1111, 8'h00, 0, 0, 4'b1111, 0, 32'h0, 0, 0, 0));
        // Synchronous clear restores b_ptr = 3
        vecs.push_back(mk(4'b1111, 4'b1111, 8'h00, 0, 1, 4'b1111, 0, 32'h0, 0, 0, 0));
        // Round-robin 0,1,2,3,0,1
        vecs.push_back(mk(4'b1111, 4'b1111, 8'h10, 0, 0, 4'b1110, 1, 32'h10, 0, 1, 0));
        vecs.push_back(mk(4'b1111, 4'b1111, 8'h20, 0, 0, 4'b1101, 1, 32'h21, 1, 1, 0));
        vecs.push_back(mk(4'b1111, 4'b1111, 8'h30, 0, 0, 4'b1011, 1, 32'h32, 2, 1, 0));
        vecs.push_back(mk(4'b1111, 4'b1111, 8'h40, 0, 0, 4'b0111, 1, 32'h43, 3, 1, 0));
        vecs.push_back(mk(4'b1111, 4'b1111, 8'h50, 0, 0, 4'b1110, 1, 32'h50, 0, 1, 0));
        vecs.push_back(mk(4'b1111, 4'b1111, 8'h60, 0, 0, 4'b1101, 1, 32'h61, 1, 1, 0));
        // Backpressure: held beat, all busy, then next beat one cycle after release
        vecs.push_back(mk(4'b1111, 4'b1111, 8'h70, 1, 0, 4'b1111, 1, 32'h61, 1, 1, 0));
        vecs.push_back(mk(4'b1111, 4'b1111, 8'h70, 1, 0, 4'b1111, 1, 32'h61, 1, 1, 0));
        vecs.push_back(mk(4'b1111, 4'b1111, 8'h70, 1, 0, 4'b1111, 1, 32'h61, 1, 1, 0));
        vecs.push_back(mk(4'b1111, 4'b1111, 8'h70, 0, 0, 4'b1011, 1, 32'h72, 2, 1, 0));
        vecs.push_back(mk(4'b0000, 4'b1111, 8'h00, 0, 0, 4'b1111, 0, 32'h0, 0, 0, 0));
        // Empty slot loads even with downstream busy
        vecs.push_back(mk(4'b0100, 4'b1111, 8'h12, 1, 0, 4'b1011, 1, 32'h14, 2, 1, 0));
        vecs.push_back(mk(4'b0000, 4'b1111, 8'h00, 0, 0, 4'b1111, 0, 32'h0, 0, 0, 0));
        // Locked packet from requester 1 while requester 0 waits
        vecs.push_back(mk(4'b0001, 4'b1111, 8'h80, 0, 0, 4'b1110, 1, 32'h80, 0, 1, 0));
        vecs.push_back(mk(4'b0011, 4'b0001, 8'h90, 0, 0, 4'b1101, 1, 32'h91, 1, 0, 1));
        vecs.push_back(mk(4'b0011, 4'b0001, 8'hA0, 0, 0, 4'b1101, 1, 32'hA1, 1, 0, 1));
        vecs.push_back(mk(4'b0011, 4'b0011, 8'hB0, 0, 0, 4'b1101, 1, 32'hB1, 1, 1, 0));
        vecs.push_back(mk(4'b0001, 4'b0001, 8'hC0, 0, 0, 4'b1110, 1, 32'hC0, 0, 1, 0));
        vecs.push_back(mk(4'b0000, 4'b0000, 8'h00, 0, 0, 4'b1111, 0, 32'h0, 0, 0, 0));
        // Lock with owner gap: bubbles, requester 0 blocked
        vecs.push_back(mk(4'b1001, 4'b0111, 8'hD0, 0, 0, 4'b0111, 1, 32'hD3, 3, 0, 1));
        vecs.push_back(mk(4'b0001, 4'b0001, 8'hD0, 0, 0, 4'b1111, 0, 32'h0, 0, 0, 1));
        vecs.push_back(mk(4'b0001, 4'b0001, 8'hD0, 0, 0, 4'b1111, 0, 32'h0, 0, 0, 1));
        vecs.push_back(mk(4'b1001, 4'b1001, 8'hE0, 0, 0, 4'b0111, 1, 32'hE3, 3, 1, 0));
        vecs.push_back(mk(4'b0001, 4'b0001, 8'hF0, 0, 0, 4'b1110, 1, 32'hF0, 0, 1, 0));
        vecs.push_back(mk(4'b0000, 4'b0000, 8'h00, 0, 0, 4'b1111, 0, 32'h0, 0, 0, 0));

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", 32'(bus.oREQ_BUSY), 32'hF);
        chk("reset valid", 32'(bus.oNEXT_VALID), 32'h0);
        chk("reset locked", 32'(bus.oLOCKED), 32'h0);
        chk("reset data", bus.oNEXT_DATA, 32'h0);
        chk("reset id", 32'(bus.oNEXT_ID), 32'h0);
        chk("reset last", 32'(bus.oNEXT_LAST), 32'h0);
        rst = 1'b0;

        // Table-driven vectors
        for (int k = 0; k < vecs.size(); k++) begin
            drive(vecs[k].v, vecs[k].l, vecs[k].tag, vecs[k].nb);
            rst_sync = vecs[k].rs;
            @(negedge clk);
            chk($sformatf("v%0d busy", k), 32'(bus.oREQ_BUSY), 32'(vecs[k].e_busy));
            @(posedge clk);
            #1;
            rst_sync = 1'b0;
            chk_out($sformatf("v%0d", k), vecs[k].e_valid, vecs[k].e_data, vecs[k].e_id,
                    vecs[k].e_last, vecs[k].e_lock);
        end

        // Async reset while locked with a full slot
        drive(4'b0010, 4'b0000, 8'h40, 1'b0);
        @(posedge clk);
        #1;
        chk_out("async pre", 1'b1, 32'h41, 2'd1, 1'b0, 1'b1);
        drive(4'b0010, 4'b0000, 8'h40, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        chk("async valid", 32'(bus.oNEXT_VALID), 32'h0);
        chk("async locked", 32'(bus.oLOCKED), 32'h0);
        chk("async busy", 32'(bus.oREQ_BUSY), 32'hF);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(4'b1111, 4'b1111, 8'h50, 1'b0);
        @(negedge clk);
        chk("async post busy", 32'(bus.oREQ_BUSY), 32'hE);
        @(posedge clk);
        #1;
        chk_out("async post", 1'b1, 32'h50, 2'd0, 1'b1, 1'b0);

        // Synchronous clear while locked: takes effect only at the edge
        drive(4'b0100, 4'b0000, 8'h60, 1'b0);
        @(posedge clk);
        #1;
        chk_out("sync pre", 1'b1, 32'h62, 2'd2, 1'b0, 1'b1);
        rst_sync = 1'b1;
        drive(4'b1111, 4'b1111, 8'h60, 1'b0);
        #1;
        chk("sync busy", 32'(bus.oREQ_BUSY), 32'hF);
        chk("sync held valid", 32'(bus.oNEXT_VALID), 32'h1);
        chk("sync held locked", 32'(bus.oLOCKED), 32'h1);
        @(posedge clk);
        #1;
        chk("sync valid", 32'(bus.oNEXT_VALID), 32'h0);
        chk("sync locked", 32'(bus.oLOCKED), 32'h0);
        rst_sync = 1'b0;
        drive(4'b1111, 4'b1111, 8'h70, 1'b0);
        @(negedge clk);
        chk("sync post busy", 32'(bus.oREQ_BUSY), 32'hE);
        @(posedge clk);
        #1;
        chk_out("sync post", 1'b1, 32'h70, 2'd0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
